fp_issue_ctrl: RTL and testbench

Request sequencer that sits between the integer pipeline's FP dispatch and the FPU execute wrapper (`fp_unit`). It is the initiator end of the `fp_exe_in_type` / `fp_exe_out_type` interface:
- buffers FP operation requests in a small FIFO;
- launches each one with a single-cycle `enable` pulse;
- waits for the execute unit's `ready`;
- returns result, flags and tag through a valid/ready response port.

One operation is outstanding at a time. Ordering is strictly in-order.

---
 rtl/fp_wire.sv | 69 ++++++
 rtl/fp_issue_fifo.sv | 63 ++++++
 rtl/fp_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_fp_issue_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_wire.sv
// Shared FP pipeline wire types: execute-unit interface plus the issue sequencer's
// request/response records, state encoding and canonical timeout result.
package fp_wire;

    typedef struct packed {
        logic       fmadd;
        logic       fmsub;
        logic       fnmsub;
        logic       fnmadd;
        logic       fadd;
        logic       fsub;
        logic       fmul;
        logic       fdiv;
        logic       fsqrt;
        logic       fsgnj;
        logic       fcmp;
        logic       fmax;
        logic       fclass;
        logic       fmv_i2f;
        logic       fmv_f2i;
        logic       fcvt_i2f;
        logic       fcvt_f2i;
        logic [1:0] fcvt_op;
    } fp_operation_type;

    typedef struct packed {
        logic [63:0]      data1;
        logic [63:0]      data2;
        logic [63:0]      data3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        logic             enable;
    } fp_exe_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_exe_out_type;

    typedef struct packed {
        logic [63:0]      data1;
        logic [63:0]      data2;
        logic [63:0]      data3;
        fp_operation_type op;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        logic [4:0]       tag;
    } fp_issue_req_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic [4:0]  tag;
        logic        timeout;
    } fp_issue_rsp_type;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } fp_issue_state_type;

    localparam logic [63:0] FP_ISSUE_NAN = 64'h7FF8000000000000;
    localparam logic [4:0]  FP_ISSUE_NV  = 5'b10000;

endpackage

// File: rtl/fp_issue_fifo.sv
// Small request FIFO for fp_issue_ctrl; head is readable combinationally so an
// empty FIFO can be bypassed by the sequencer.
module fp_issue_fifo
    import fp_wire::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  fp_issue_req_type       wr_data,
    output fp_issue_req_type       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    fp_issue_req_type mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    // Popping an empty FIFO is legal only when the same-cycle push is being bypassed.
    assign pop_ok  = pop && (!empty || push_ok);
    assign rd_data = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// In-order FP request sequencer in front of the execute unit: one op in flight.
// Optional WAIT watchdog enabled by defining FP_ISSUE_TIMEOUT_EN.
module fp_issue_ctrl
    import fp_wire::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  fp_issue_req_type req,
    output fp_exe_in_type    fp_exe_i,
    input  fp_exe_out_type   fp_exe_o,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output fp_issue_rsp_type rsp,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);

    fp_issue_state_type state_reg, state_next;
    fp_exe_in_type      exe_reg, exe_next;
    fp_issue_rsp_type   rsp_reg, rsp_next;
    logic [4:0]         tag_reg, tag_next;

    fp_issue_req_type   fifo_head, head;
    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW:0]        fifo_count;
    logic               head_avail, launch, capture;

    assign req_ready  = !fifo_full && !reset;
    assign fifo_push  = req_valid && req_ready;
    // An empty FIFO forwards the incoming request so issue starts the cycle after the handshake.
    assign head_avail = !fifo_empty || fifo_push;
    assign head       = fifo_empty ? req : fifo_head;

    fp_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (req),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef FP_ISSUE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_reg;
    logic          expire;

    assign expire = (state_reg == WAIT) && !fp_exe_o.ready && (wait_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset || state_next == ISSUE) begin
            wait_cnt_reg <= '0;
        end else if (state_reg == WAIT) begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
`endif

    always_comb begin
        state_next      = state_reg;
        exe_next        = exe_reg;
        exe_next.enable = 1'b0;
        rsp_next        = rsp_reg;
        tag_next        = tag_reg;
        fifo_pop        = 1'b0;
        launch          = 1'b0;
        capture         = 1'b0;

        case (state_reg)
            IDLE:  launch = head_avail;
            ISSUE: begin
                state_next = WAIT;
                capture    = fp_exe_o.ready;
            end
            WAIT:  capture = fp_exe_o.ready;
            RESP:  begin
                if (rsp_ready) begin
                    launch     = head_avail;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (launch) begin
            fifo_pop   = 1'b1;
            exe_next   = '{data1: head.data1, data2: head.data2, data3: head.data3,
                           op: head.op, fmt: head.fmt, rm: head.rm, enable: 1'b1};
            tag_next   = head.tag;
            state_next = ISSUE;
        end
        if (capture) begin
            rsp_next   = '{result: fp_exe_o.result, flags: fp_exe_o.flags,
                           tag: tag_reg, timeout: 1'b0};
            state_next = RESP;
        end
`ifdef FP_ISSUE_TIMEOUT_EN
        if (expire) begin
            rsp_next   = '{result: FP_ISSUE_NAN, flags: FP_ISSUE_NV,
                           tag: tag_reg, timeout: 1'b1};
            state_next = RESP;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            exe_reg   <= '0;
            rsp_reg   <= '0;
            tag_reg   <= '0;
        end else begin
            state_reg <= state_next;
            exe_reg   <= exe_next;
            rsp_reg   <= rsp_next;
            tag_reg   <= tag_next;
        end
    end

    assign fp_exe_i  = exe_reg;
    assign rsp       = rsp_reg;
    assign rsp_valid = (state_reg == RESP);
    assign busy      = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Scoreboard bench for fp_issue_ctrl: directed requests, a latency-programmable
// execute-unit model, and a monitor that checks responses and enable rules.
`timescale 1ns/1ps
module tb_fp_issue_ctrl;
    import fp_wire::*;

    localparam int DEPTH = 4;
`ifdef FP_ISSUE_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    fp_issue_req_type req = '0;
    fp_exe_in_type    fp_exe_i;
    fp_exe_out_type   fp_exe_o;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    fp_issue_rsp_type rsp;
    logic             busy;

    always #5 clock = ~clock;

    fp_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req       (req),
        .fp_exe_i  (fp_exe_i),
        .fp_exe_o  (fp_exe_o),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp       (rsp),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int last_hs = 0;
    int k;

    fp_issue_rsp_type exp_q[$];
    logic [68:0]      unit_q[$];
    int               en_q[$];
    int               rv_q[$];
    int               acc_q[$];
    int               rr_q[$];

    always @(posedge clock) cyc++;

    // Execute-unit model: answers each enable after unit_lat cycles unless held.
    bit          unit_hold = 1'b0;
    bit          inject = 1'b0;
    int          unit_lat = 0;
    bit          m_pend = 1'b0;
    int          m_cnt = 0;
    logic [68:0] m_r;

    initial begin
        fp_exe_o = '0;
        forever begin
            @(posedge clock);
            #2;
            fp_exe_o = '0;
            if (reset) begin
                m_pend = 1'b0;
            end else begin
                if (fp_exe_i.enable) begin
                    m_pend = 1'b1;
                    m_cnt  = unit_lat;
                    m_r    = (unit_q.size() != 0) ? unit_q.pop_front() : '0;
                end
                if (inject) begin
                    fp_exe_o.ready  = 1'b1;
                    fp_exe_o.result = 64'hDEADBEEF00000000;
                end else if (m_pend && !unit_hold) begin
                    if (m_cnt == 0) begin
                        fp_exe_o.ready  = 1'b1;
                        fp_exe_o.result = m_r[68:5];
                        fp_exe_o.flags  = m_r[4:0];
                        m_pend = 1'b0;
                    end else begin
                        m_cnt--;
                    end
                end
            end
        end
    end

    // Monitor and scoreboard.
    logic             prev_en = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0, prev_acc = 1'b0;
    fp_issue_rsp_type prev_rsp = '0;
    fp_issue_rsp_type exp_r;

    always @(negedge clock) begin
        if (!reset) begin
            if (fp_exe_i.enable) en_q.push_back(cyc);
            if (rsp_valid && !prev_rv) rv_q.push_back(cyc);
            if (req_ready && !prev_rr) rr_q.push_back(cyc);
            if (req_valid && req_ready) hs_cnt++;
            if (fp_exe_i.enable && prev_en) begin
                fails++;
                $display("FAIL enable_twice: enable high in cycles %0d and %0d, required single-cycle pulse", cyc - 1, cyc);
            end
            if (fp_exe_i.enable && rsp_valid) begin
                fails++;
                $display("FAIL enable_during_rsp: enable=1 with rsp_valid=1 in cycle %0d, required enable=0", cyc);
            end
            if (rsp_valid && prev_rv && !prev_acc && rsp != prev_rsp) begin
                fails++;
                $display("FAIL rsp_stable: rsp changed to %h from %h while unaccepted", rsp, prev_rsp);
            end
            if (rsp_valid && rsp_ready) begin
                acc_q.push_back(cyc);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL rsp_unexpected: got tag=%0d result=%h, required no response", rsp.tag, rsp.result);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (rsp !== exp_r) begin
                        fails++;
                        $display("FAIL rsp_data: got result=%h flags=%b tag=%0d timeout=%b, required result=%h flags=%b tag=%0d timeout=%b",
                                 rsp.result, rsp.flags, rsp.tag, rsp.timeout,
                                 exp_r.result, exp_r.flags, exp_r.tag, exp_r.timeout);
                    end else begin
                        $display("[TB] cycle %0d rsp tag=%0d result=%h flags=%b timeout=%b ok",
                                 cyc, rsp.tag, rsp.result, rsp.flags, rsp.timeout);
                    end
                end
            end
        end
        prev_en  = fp_exe_i.enable;
        prev_rv  = rsp_valid;
        prev_rr  = req_ready;
        prev_acc = rsp_valid && rsp_ready;
        prev_rsp = rsp;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req_val);
        tests++;
        if (act !== req_val) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req_val);
        end
    endtask

    function automatic fp_issue_req_type mk_req(input logic [4:0] tag, input logic [63:0] d1,
                                               input logic [63:0] d2, input bit sgnj);
        fp_issue_req_type r;
        r = '0;
        r.data1 = d1;
        r.data2 = d2;
        r.tag   = tag;
        r.fmt   = 2'b01;
        if (sgnj) r.op.fsgnj = 1'b1;
        else      r.op.fadd  = 1'b1;
        return r;
    endfunction

    task automatic push_expect(input logic [4:0] tag, input logic [63:0] res,
                               input logic [4:0] flg, input bit tmo);
        fp_issue_rsp_type e;
        e.result  = res;
        e.flags   = flg;
        e.tag     = tag;
        e.timeout = tmo;
        exp_q.push_back(e);
        unit_q.push_back({res, flg});
    endtask

    // Called and returns at #1 after a rising edge.
    task automatic send(input fp_issue_req_type r, input logic [63:0] res,
                        input logic [4:0] flg, input bit tmo);
        int n;
        n = 0;
        req_valid = 1'b1;
        req = r;
        @(negedge clock);
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clock);
        end
        if (!req_ready) begin
            fails++;
            $display("FAIL send_timeout: req_ready=0 for tag %0d, required handshake", r.tag);
        end else begin
            last_hs = cyc;
            push_expect(r.tag, res, flg, tmo);
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clock);
        while ((busy || rsp_valid) && n < 300) begin
            n++;
            @(negedge clock);
        end
        tests++;
        if (busy || rsp_valid) begin
            fails++;
            $display("FAIL %s_idle: busy=%b rsp_valid=%b after %0d cycles, required idle", name, busy, rsp_valid, n);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        en_q.delete();
        rv_q.delete();
        acc_q.delete();
        rr_q.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_req_ready_during", req_ready, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_req_ready_after", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_exe_zero", fp_exe_i == '0, 1);
        check("reset_rsp_zero", rsp == '0, 1);
        @(posedge clock);
        #1;

        // fadd 1.0 + 2.0, unit answers 2 cycles after enable
        clear_logs();
        unit_lat = 2;
        send(mk_req(5'd3, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0),
             64'h4008000000000000, 5'd0, 1'b0);
        wait_idle("fadd");
        check("fadd_enable_count", en_q.size(), 1);
        check("fadd_enable_cycle", en_q[0] - last_hs, 1);
        check("fadd_rsp_cycle", rv_q[0] - last_hs, 4);

        // fsgnj answered in the enable cycle, then a stray ready while idle
        clear_logs();
        unit_lat = 0;
        send(mk_req(5'd7, 64'h3FF0000000000000, 64'hC000000000000000, 1'b1),
             64'hBFF0000000000000, 5'd0, 1'b0);
        wait_idle("fsgnj");
        check("fsgnj_enable_cycle", en_q[0] - last_hs, 1);
        check("fsgnj_rsp_cycle", rv_q[0] - en_q[0], 1);
        inject = 1'b1;
        @(posedge clock);
        #1;
        inject = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("stray_ready_no_rsp", rv_q.size(), 1);
        check("stray_ready_busy", busy, 0);

        // Fill with unit stalled: 5 handshakes then full
        clear_logs();
        unit_hold = 1'b1;
        unit_lat = 0;
        hs_cnt = 0;
        k = 0;
        req_valid = 1'b1;
        repeat (8) begin
            req = mk_req(5'(10 + k), 64'(k), 64'h0, 1'b0);
            @(negedge clock);
            if (req_ready) begin
                push_expect(5'(10 + k), 64'h4000000000000000 + 64'(k), 5'(k), 1'b0);
                k++;
            end
            @(posedge clock);
            #1;
        end
        req_valid = 1'b0;
        check("full_handshakes", hs_cnt, 5);
        check("full_req_ready", req_ready, 0);
        check("full_busy", busy, 1);
        clear_logs();
        unit_hold = 1'b0;
        wait_idle("full_drain");
        check("full_reopen_lag", rr_q[0] - acc_q[0], 1);
        check("full_drain_count", acc_q.size(), 5);

        // Response back-pressure with two queued behind the in-flight op
        clear_logs();
        unit_lat = 1;
        rsp_ready = 1'b0;
        send(mk_req(5'd20, 64'h1, 64'h2, 1'b0), 64'h0000000000000020, 5'b00001, 1'b0);
        send(mk_req(5'd21, 64'h3, 64'h4, 1'b0), 64'h0000000000000021, 5'b00010, 1'b0);
        send(mk_req(5'd22, 64'h5, 64'h6, 1'b0), 64'h0000000000000022, 5'b00100, 1'b0);
        k = 0;
        while (rv_q.size() == 0 && k < 50) begin
            k++;
            @(negedge clock);
        end
        repeat (10) @(negedge clock);
        check("stall_no_enable", en_q.size(), 1);
        check("stall_rsp_held", rsp_valid, 1);
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        wait_idle("stall");
        check("stall_next_enable", en_q[1] - acc_q[0], 1);
        check("stall_total", acc_q.size(), 3);

        // Reset while waiting with three entries queued
        clear_logs();
        unit_hold = 1'b1;
        unit_lat = 0;
        send(mk_req(5'd1, 64'h1, 64'h1, 1'b0), 64'h1, 5'd0, 1'b0);
        send(mk_req(5'd2, 64'h2, 64'h2, 1'b0), 64'h2, 5'd0, 1'b0);
        send(mk_req(5'd3, 64'h3, 64'h3, 1'b0), 64'h3, 5'd0, 1'b0);
        send(mk_req(5'd4, 64'h4, 64'h4, 1'b0), 64'h4, 5'd0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        unit_q.delete();
        @(negedge clock);
        check("midrst_busy", busy, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_exe_zero", fp_exe_i == '0, 1);
        check("midrst_rsp_zero", rsp == '0, 1);
        @(posedge clock);
        #1;
        unit_hold = 1'b0;
        inject = 1'b1;
        @(posedge clock);
        #1;
        inject = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("midrst_no_rsp", rv_q.size(), 0);
        check("midrst_no_enable", en_q.size(), 1);

`ifdef FP_ISSUE_TIMEOUT_EN
        // Watchdog: no ready at all
        clear_logs();
        unit_hold = 1'b1;
        send(mk_req(5'd9, 64'h9, 64'h9, 1'b0), 64'h7FF8000000000000, 5'b10000, 1'b1);
        wait_idle("timeout");
        check("timeout_rsp_cycle", rv_q[0] - en_q[0], 17);
        unit_hold = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check("timeout_stale_ignored", rv_q.size(), 1);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "global timeout");
    end

endmodule
